photo_sensor_conditioner: RTL and testbench

//   Upstream front-end of the SBqM people counter. Takes the two raw,

---
 rtl/sbqm_pkg.sv | 21 ++
 rtl/sensor_debounce.sv | 63 ++++++
 rtl/photo_sensor_conditioner.sv | 79 +++++++
 tb/tb_photo_sensor_conditioner.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/sbqm_pkg.sv
// Shared definitions for the SBqM people-counter front end and counter stage.
package sbqm_pkg;

    // Photo-sensor line levels: the beam pulls the line low when broken.
    localparam logic SENSOR_IDLE   = 1'b1;
    localparam logic SENSOR_BROKEN = 1'b0;

    // Default debounce settings; 2**DEB_W_DEF must exceed DEB_CYCLES_DEF.
    localparam int DEB_CYCLES_DEF = 16;
    localparam int DEB_W_DEF      = 5;

    // Registered event outputs of the conditioner.
    typedef struct packed {
        logic enter;
        logic exit_ev;
        logic collision;
    } pulse_t;

    localparam pulse_t PULSE_NONE = '{enter: 1'b0, exit_ev: 1'b0, collision: 1'b0};

endpackage

// File: rtl/sensor_debounce.sv
// One photo-sensor channel: two-flop synchroniser, stable-count debounce and
// detection of the debounced level falling (beam broken).
module sensor_debounce
    import sbqm_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int DEB_W      = DEB_W_DEF
) (
    input  logic clk,
    input  logic rest_n,
    input  logic raw,
    output logic level,
    output logic fall
);

    localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic [DEB_W-1:0] cnt_q, cnt_d;
    logic             flip;

    // Next-state: any sample that agrees with the held level restarts the count;
    // the level only moves after DEB_CYCLES disagreeing samples in a row.
    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        flip    = 1'b0;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            flip    = 1'b1;
            level_d = sync2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers; reset leaves the channel reading a clear beam.
    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
            sync1_q <= SENSOR_IDLE;
            sync2_q <= SENSOR_IDLE;
            level_q <= SENSOR_IDLE;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    // fall marks the edge on which the level drops, so a pulse registered from
    // it lines up with the new level.
    assign level = level_q;
    assign fall  = flip && (level_q == SENSOR_IDLE);

endmodule

// File: rtl/photo_sensor_conditioner.sv
// Front end of the people counter: debounces the back (enter) and forward
// (exit) beams and turns each accepted beam break into a single-cycle pulse.
// Enter always wins a same-edge tie; the exit is replayed one cycle later.
module photo_sensor_conditioner
    import sbqm_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int DEB_W      = DEB_W_DEF
) (
    input  logic clk,
    input  logic rest_n,
    input  logic backphoto_raw,
    input  logic forwardphoto_raw,
    output logic backphoto,
    output logic forwardphoto,
    output logic enter_pulse,
    output logic exit_pulse,
    output logic collision
);

    logic   fall_b, fall_f;
    logic   pending_exit_q, pending_exit_d;
    logic   pending_enter_q, pending_enter_d;
    pulse_t pulse_q, pulse_d;

    sensor_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_back (
        .clk    (clk),
        .rest_n (rest_n),
        .raw    (backphoto_raw),
        .level  (backphoto),
        .fall   (fall_b)
    );

    sensor_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_forward (
        .clk    (clk),
        .rest_n (rest_n),
        .raw    (forwardphoto_raw),
        .level  (forwardphoto),
        .fall   (fall_f)
    );

    // Arbitration: a queued exit always goes out first; an enter arriving in
    // that same cycle is held for one cycle so the two never overlap.
    always_comb begin
        pulse_d         = PULSE_NONE;
        pending_exit_d  = 1'b0;
        pending_enter_d = 1'b0;
        if (pending_exit_q) begin
            pulse_d.exit_ev = 1'b1;
            pending_enter_d = fall_b;
        end else if ((fall_b || pending_enter_q) && fall_f) begin
            pulse_d.enter     = 1'b1;
            pulse_d.collision = fall_b;
            pending_exit_d    = 1'b1;
        end else if (fall_b || pending_enter_q) begin
            pulse_d.enter = 1'b1;
        end else if (fall_f) begin
            pulse_d.exit_ev = 1'b1;
        end
    end

    // Arbitration registers; reset discards any queued event.
    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
            pending_exit_q  <= 1'b0;
            pending_enter_q <= 1'b0;
            pulse_q         <= PULSE_NONE;
        end else begin
            pending_exit_q  <= pending_exit_d;
            pending_enter_q <= pending_enter_d;
            pulse_q         <= pulse_d;
        end
    end

    assign enter_pulse = pulse_q.enter;
    assign exit_pulse  = pulse_q.exit_ev;
    assign collision   = pulse_q.collision;

endmodule

// File: tb/tb_photo_sensor_conditioner.sv
// Directed bench for photo_sensor_conditioner with DEB_CYCLES=4, DEB_W=3.
// A raw change made just after an edge shows on the debounced level (and the
// matching pulse) after the 6th following rising edge.
module tb_photo_sensor_conditioner;

    logic clk = 1'b0;
    logic rest_n;
    logic backphoto_raw;
    logic forwardphoto_raw;
    logic backphoto;
    logic forwardphoto;
    logic enter_pulse;
    logic exit_pulse;
    logic collision;

    int checks   = 0;
    int failures = 0;
    int n_enter, n_exit, n_coll, n_ovl;

    photo_sensor_conditioner #(.DEB_CYCLES(4), .DEB_W(3)) dut (
        .clk              (clk),
        .rest_n           (rest_n),
        .backphoto_raw    (backphoto_raw),
        .forwardphoto_raw (forwardphoto_raw),
        .backphoto        (backphoto),
        .forwardphoto     (forwardphoto),
        .enter_pulse      (enter_pulse),
        .exit_pulse       (exit_pulse),
        .collision        (collision)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        n_enter = 0;
        n_exit  = 0;
        n_coll  = 0;
        n_ovl   = 0;
    endtask

    // One clock; outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (enter_pulse) n_enter++;
        if (exit_pulse) n_exit++;
        if (collision) n_coll++;
        if (enter_pulse && exit_pulse) n_ovl++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        clr();
        rest_n           = 1'b0;
        backphoto_raw    = 1'b0;
        forwardphoto_raw = 1'b1;

        // 1: reset with back beam already broken
        steps(3);
        check("rst_backphoto", backphoto, 1);
        check("rst_forwardphoto", forwardphoto, 1);
        check("rst_enter", enter_pulse, 0);
        check("rst_exit", exit_pulse, 0);
        check("rst_collision", collision, 0);
        rest_n = 1'b1;
        clr();
        steps(5);
        check("t1_level_before", backphoto, 1);
        check("t1_no_early_enter", n_enter, 0);
        step();
        check("t1_level_after", backphoto, 0);
        check("t1_enter", enter_pulse, 1);
        check("t1_exit", exit_pulse, 0);
        step();
        check("t1_enter_single", enter_pulse, 0);
        steps(5);
        check("t1_enter_count", n_enter, 1);
        check("t1_exit_count", n_exit, 0);

        // 3: beam restored
        clr();
        backphoto_raw = 1'b1;
        steps(5);
        check("t3_level_before", backphoto, 0);
        step();
        check("t3_level_after", backphoto, 1);
        steps(5);
        check("t3_enter_count", n_enter, 0);
        check("t3_exit_count", n_exit, 0);
        check("t3_coll_count", n_coll, 0);

        // 2: bouncing break
        clr();
        for (int r = 0; r < 5; r++) begin
            backphoto_raw = 1'b0;
            steps(3);
            backphoto_raw = 1'b1;
            step();
        end
        check("t2_bounce_level", backphoto, 1);
        check("t2_bounce_no_enter", n_enter, 0);
        backphoto_raw = 1'b0;
        steps(5);
        check("t2_no_early_enter", n_enter, 0);
        step();
        check("t2_enter_at_6", enter_pulse, 1);
        steps(4);
        check("t2_enter_count", n_enter, 1);
        check("t2_level", backphoto, 0);
        check("t2_exit_count", n_exit, 0);
        backphoto_raw = 1'b1;
        steps(8);

        // 4: both beams break together
        clr();
        backphoto_raw    = 1'b0;
        forwardphoto_raw = 1'b0;
        steps(5);
        check("t4_no_early", n_enter + n_exit, 0);
        step();
        check("t4_enter_n", enter_pulse, 1);
        check("t4_coll_n", collision, 1);
        check("t4_exit_n", exit_pulse, 0);
        step();
        check("t4_enter_n1", enter_pulse, 0);
        check("t4_coll_n1", collision, 0);
        check("t4_exit_n1", exit_pulse, 1);
        step();
        check("t4_exit_n2", exit_pulse, 0);
        check("t4_counts", {n_enter[7:0], n_exit[7:0], n_coll[7:0], n_ovl[7:0]}, 32'h01010100);
        backphoto_raw    = 1'b1;
        forwardphoto_raw = 1'b1;
        steps(8);
        check("t4_restored", {backphoto, forwardphoto}, 2'b11);

        // 5: back breaks one cycle before forward, no collision
        clr();
        backphoto_raw = 1'b0;
        step();
        forwardphoto_raw = 1'b0;
        steps(5);
        check("t5_enter", enter_pulse, 1);
        check("t5_exit_lo", exit_pulse, 0);
        check("t5_coll_lo", collision, 0);
        step();
        check("t5_exit", exit_pulse, 1);
        check("t5_enter_lo", enter_pulse, 0);
        backphoto_raw    = 1'b1;
        forwardphoto_raw = 1'b1;
        steps(8);
        check("t5_counts", {n_enter[7:0], n_exit[7:0], n_coll[7:0], n_ovl[7:0]}, 32'h01010000);

        // 6: reset while an exit is queued behind a collision
        clr();
        backphoto_raw    = 1'b0;
        forwardphoto_raw = 1'b0;
        steps(6);
        check("t6_coll_before_rst", collision, 1);
        rest_n = 1'b0;
        #1;
        check("t6_rst_exit", exit_pulse, 0);
        check("t6_rst_enter", enter_pulse, 0);
        check("t6_rst_levels", {backphoto, forwardphoto}, 2'b11);
        steps(2);
        clr();
        rest_n = 1'b1;
        step();
        check("t6_no_stale_exit", exit_pulse, 0);
        steps(4);
        check("t6_restart_level", backphoto, 1);
        check("t6_restart_quiet", n_enter + n_exit, 0);
        step();
        check("t6_enter_again", enter_pulse, 1);
        check("t6_coll_again", collision, 1);
        step();
        check("t6_exit_again", exit_pulse, 1);
        check("t6_overlap", n_ovl, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
